// File: rtl/line_option_fifo.sv
// line_option_fifo: circular option store that replays per-line candidate options to a solver.
// Loaded once with index words followed by options, then pops words round after round, requeueing
// each index word and appending the options the solver puts back.
// Defining LINE_OPTION_FIFO_STATS_EN adds the hwm and pb_rounds statistics ports.
module line_option_fifo #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned MAX_LINES = 22,
    parameter int unsigned CNT_W     = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_valid,
    input  logic [WIDTH-1:0]           load_data,
    input  logic                       load_is_index,
    input  logic                       load_done,
    output logic                       load_ready,
    input  logic                       read_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       dout_is_index,
    input  logic                       put_back,
    input  logic [WIDTH-1:0]           put_back_data,
    input  logic                       halt,
    output logic                       stall,
    output logic [MAX_LINES*CNT_W-1:0] options_amnt,
    output logic [7:0]                 round_cnt,
    output logic                       overflow
`ifdef LINE_OPTION_FIFO_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]     hwm,
    output logic [15:0]                pb_rounds
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned IDX_W = $clog2(MAX_LINES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [CNT_W-1:0]   amnt_q [MAX_LINES];
    logic [CNT_W-1:0]   amnt_d [MAX_LINES];
    // Line currently being built: the load line in LOAD, the tail line in RUN.
    logic [IDX_W-1:0]   line_q, line_d;
    logic               tail_open_q, tail_open_d;
    logic [CNT_W-1:0]   tail_cnt_q, tail_cnt_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               pend_q, pend_d;
    logic [WIDTH-1:0]   pend_idx_q, pend_idx_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               dout_is_index_q, dout_is_index_d;
    logic [7:0]         round_q, round_d;
    logic               overflow_q, overflow_d;

    logic [WIDTH-1:0]   mem [DEPTH];

    logic               full, empty, in_run, pop;
    logic               load_req, pb_req, pend_req, wr_req, wr_en;
    logic [WIDTH-1:0]   wr_data, head_word;
    logic [CNT_W-1:0]   head_amnt;

    function automatic logic line_ok(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < (IDX_W + 1)'(MAX_LINES);
    endfunction

    // Handshake and request decode.
    always_comb begin
        full      = (count_q == (PTR_W + 1)'(DEPTH));
        empty     = (count_q == '0);
        in_run    = (state_q == StRun);
        // An index pop needs the skid slot; hold off while it is still occupied.
        stall     = in_run && pend_q && (rem_q == '0);
        load_ready = (state_q == StLoad) && !full;
        pop       = in_run && read_en && !empty && !stall;
        load_req  = load_valid && ((state_q == StIdle) || (state_q == StLoad));
        pb_req    = in_run && put_back;
        // The pending index only reaches the tail in a cycle without a put-back.
        pend_req  = in_run && pend_q && !put_back;
        wr_req    = load_req || pb_req || pend_req;
        wr_en     = wr_req && !full;
        wr_data   = load_req ? load_data : (pb_req ? put_back_data : pend_idx_q);
        head_word = mem[head_q];
    end

    // Option count of the line whose index sits at head.
    always_comb begin
        head_amnt = '0;
        for (int i = 0; i < MAX_LINES; i++) begin
            if (head_word[IDX_W-1:0] == IDX_W'(i)) head_amnt = amnt_q[i];
        end
    end

    // Next-state logic: pointers, line bookkeeping, head/tail sides and FSM.
    always_comb begin
        state_d         = state_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        amnt_d          = amnt_q;
        line_d          = line_q;
        tail_open_d     = tail_open_q;
        tail_cnt_d      = tail_cnt_q;
        rem_d           = rem_q;
        pend_d          = pend_q;
        pend_idx_d      = pend_idx_q;
        dout_d          = dout_q;
        dout_valid_d    = 1'b0;
        dout_is_index_d = 1'b0;
        round_d         = round_q;
        overflow_d      = overflow_q;

        if (wr_req && full) overflow_d = 1'b1;
        if (wr_en) tail_d = tail_q + PTR_W'(1);
        if (pop) head_d = head_q + PTR_W'(1);
        if (wr_en && !pop) count_d = count_q + (PTR_W + 1)'(1);
        else if (!wr_en && pop) count_d = count_q - (PTR_W + 1)'(1);

        if (load_req && !full) begin
            if (load_is_index) begin
                line_d = load_data[IDX_W-1:0];
                if (line_ok(load_data[IDX_W-1:0])) amnt_d[load_data[IDX_W-1:0]] = '0;
            end else if (line_ok(line_q) && amnt_q[line_q] != CNT_MAX) begin
                amnt_d[line_q] = amnt_q[line_q] + CNT_W'(1);
            end
        end

        if (pb_req && !full && tail_cnt_q != CNT_MAX) tail_cnt_d = tail_cnt_q + CNT_W'(1);

        if (pend_req) begin
            pend_d = 1'b0;
            if (!full) begin
                // Closing the previous tail line publishes its survivor count.
                if (tail_open_q && line_ok(line_q)) amnt_d[line_q] = tail_cnt_q;
                line_d      = pend_idx_q[IDX_W-1:0];
                tail_cnt_d  = '0;
                tail_open_d = 1'b1;
            end
        end

        if (pop) begin
            dout_d       = head_word;
            dout_valid_d = 1'b1;
            if (rem_q == '0) begin
                dout_is_index_d = 1'b1;
                rem_d           = head_amnt;
                pend_d          = 1'b1;
                pend_idx_d      = head_word;
                if (head_word == '0) round_d = round_q + 8'd1;
            end else begin
                rem_d = rem_q - CNT_W'(1);
            end
        end

        unique case (state_q)
            StIdle: if (load_valid) state_d = StLoad;
            StLoad: begin
                if (load_done) begin
                    state_d     = StRun;
                    rem_d       = '0;
                    pend_d      = 1'b0;
                    tail_open_d = 1'b0;
                    tail_cnt_d  = '0;
                end
            end
            StRun: begin
                if (halt) begin
                    state_d = StDone;
                    pend_d  = 1'b0;
                end
            end
            StDone: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            for (int i = 0; i < MAX_LINES; i++) amnt_q[i] <= '0;
            line_q          <= '0;
            tail_open_q     <= 1'b0;
            tail_cnt_q      <= '0;
            rem_q           <= '0;
            pend_q          <= 1'b0;
            pend_idx_q      <= '0;
            dout_q          <= '0;
            dout_valid_q    <= 1'b0;
            dout_is_index_q <= 1'b0;
            round_q         <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            amnt_q          <= amnt_d;
            line_q          <= line_d;
            tail_open_q     <= tail_open_d;
            tail_cnt_q      <= tail_cnt_d;
            rem_q           <= rem_d;
            pend_q          <= pend_d;
            pend_idx_q      <= pend_idx_d;
            dout_q          <= dout_d;
            dout_valid_q    <= dout_valid_d;
            dout_is_index_q <= dout_is_index_d;
            round_q         <= round_d;
            overflow_q      <= overflow_d;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[tail_q] <= wr_data;
    end

    // Output packing.
    always_comb begin
        options_amnt = '0;
        for (int i = 0; i < MAX_LINES; i++) options_amnt[i*CNT_W +: CNT_W] = amnt_q[i];
        dout          = dout_q;
        dout_valid    = dout_valid_q;
        dout_is_index = dout_is_index_q;
        round_cnt     = round_q;
        overflow      = overflow_q;
    end

`ifdef LINE_OPTION_FIFO_STATS_EN
    logic [PTR_W:0] hwm_q, hwm_d;
    logic [15:0]    pb_rounds_q, pb_rounds_d;

    // High-water mark and saturating count of accepted put-backs.
    always_comb begin
        hwm_d       = (count_d > hwm_q) ? count_d : hwm_q;
        pb_rounds_d = pb_rounds_q;
        if (pb_req && !full && pb_rounds_q != 16'hffff) pb_rounds_d = pb_rounds_q + 16'd1;
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q       <= '0;
            pb_rounds_q <= '0;
        end else begin
            hwm_q       <= hwm_d;
            pb_rounds_q <= pb_rounds_d;
        end
    end

    assign hwm       = hwm_q;
    assign pb_rounds = pb_rounds_q;
`endif

endmodule

// File: tb/tb_line_option_fifo.sv
// tb_line_option_fifo: directed bench with a queue-based reference model and per-cycle compare.
module tb_line_option_fifo;

    localparam int W  = 16;
    localparam int D  = 256;
    localparam int ML = 22;
    localparam int CW = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_valid = 1'b0;
    logic [W-1:0]      load_data = '0;
    logic              load_is_index = 1'b0;
    logic              load_done = 1'b0;
    logic              load_ready;
    logic              read_en = 1'b0;
    logic [W-1:0]      dout;
    logic              dout_valid;
    logic              dout_is_index;
    logic              put_back = 1'b0;
    logic [W-1:0]      put_back_data = '0;
    logic              halt = 1'b0;
    logic              stall;
    logic [ML*CW-1:0]  options_amnt;
    logic [7:0]        round_cnt;
    logic              overflow;
`ifdef LINE_OPTION_FIFO_STATS_EN
    logic [$clog2(D):0] hwm;
    logic [15:0]        pb_rounds;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    line_option_fifo #(
        .WIDTH(W),
        .DEPTH(D),
        .MAX_LINES(ML),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_is_index(load_is_index),
        .load_done(load_done),
        .load_ready(load_ready),
        .read_en(read_en),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_is_index(dout_is_index),
        .put_back(put_back),
        .put_back_data(put_back_data),
        .halt(halt),
        .stall(stall),
        .options_amnt(options_amnt),
        .round_cnt(round_cnt),
        .overflow(overflow)
`ifdef LINE_OPTION_FIFO_STATS_EN
        ,
        .hwm(hwm),
        .pb_rounds(pb_rounds)
`endif
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the store is a queue, lines are plain integer counts.
    int           m_state = 0;   // 0 idle, 1 load, 2 run, 3 done
    logic [W-1:0] m_q[$];
    int           m_amnt[32];
    int           m_line = 0;
    bit           m_open = 0;
    int           m_tcnt = 0;
    int           m_rem = 0;
    bit           m_pend = 0;
    logic [W-1:0] m_pidx = '0;
    int           m_round = 0;
    bit           m_ovf = 0;
    logic [W-1:0] m_dout = '0;
    bit           m_dv = 0;
    bit           m_di = 0;

    task automatic model_reset();
        m_state = 0; m_q.delete();
        for (int i = 0; i < 32; i++) m_amnt[i] = 0;
        m_line = 0; m_open = 0; m_tcnt = 0; m_rem = 0; m_pend = 0; m_pidx = '0;
        m_round = 0; m_ovf = 0; m_dout = '0; m_dv = 0; m_di = 0;
    endtask

    task automatic model_load();
        m_q.push_back(load_data);
        if (load_is_index) begin
            m_line = int'(load_data[4:0]);
            if (m_line < ML) m_amnt[m_line] = 0;
        end else if (m_line < ML && m_amnt[m_line] < 127) begin
            m_amnt[m_line]++;
        end
    endtask

    task automatic model_step();
        int           sz;
        bit           full, stall_now, pop, newp, op;
        logic [W-1:0] w, opi;
        sz = m_q.size();
        full = (sz >= D);
        m_dv = 0;
        m_di = 0;
        case (m_state)
            0: if (load_valid) begin model_load(); m_state = 1; end
            1: begin
                if (load_valid) begin
                    if (full) m_ovf = 1; else model_load();
                end
                if (load_done) begin
                    m_state = 2; m_rem = 0; m_pend = 0; m_open = 0; m_tcnt = 0;
                end
            end
            2: begin
                op = m_pend; opi = m_pidx; newp = 0; w = '0;
                stall_now = m_pend && (m_rem == 0);
                pop = read_en && (sz > 0) && !stall_now;
                if (pop) begin
                    w = m_q.pop_front();
                    m_dout = w; m_dv = 1;
                    if (m_rem == 0) begin
                        m_di = 1; newp = 1;
                        m_rem = (int'(w[4:0]) < ML) ? m_amnt[w[4:0]] : 0;
                        if (w == 0) m_round = (m_round + 1) % 256;
                    end else begin
                        m_rem--;
                    end
                end
                if (put_back) begin
                    if (full) m_ovf = 1;
                    else begin
                        m_q.push_back(put_back_data);
                        if (m_tcnt < 127) m_tcnt++;
                    end
                end else if (op) begin
                    if (full) m_ovf = 1;
                    else begin
                        m_q.push_back(opi);
                        if (m_open && m_line < ML) m_amnt[m_line] = m_tcnt;
                        m_line = int'(opi[4:0]); m_tcnt = 0; m_open = 1;
                    end
                    m_pend = 0;
                end
                if (newp) begin m_pend = 1; m_pidx = w; end
                if (halt) begin m_state = 3; m_pend = 0; end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [ML*CW-1:0] exp_amnt;
        exp_amnt = '0;
        for (int i = 0; i < ML; i++) exp_amnt[i*CW +: CW] = m_amnt[i][CW-1:0];
        check("dout_valid", dout_valid, m_dv);
        check("dout_is_index", dout_is_index, m_di);
        if (m_dv) check("dout", dout, m_dout);
        check("load_ready", load_ready, (m_state == 1) && (m_q.size() < D));
        check("stall", stall, (m_state == 2) && m_pend && (m_rem == 0));
        check("round_cnt", round_cnt, m_round[7:0]);
        check("overflow", overflow, m_ovf);
        check("options_amnt", options_amnt, exp_amnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [W-1:0] d, input bit idx);
        load_valid = 1'b1; load_data = d; load_is_index = idx;
        tick();
        load_valid = 1'b0; load_is_index = 1'b0;
    endtask

    task automatic finish_load();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic cyc(input bit re, input bit pb, input logic [W-1:0] pbd);
        read_en = re; put_back = pb; put_back_data = pbd;
        tick();
        read_en = 1'b0; put_back = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [CW-1:0] amnt_of(input int i);
        return options_amnt[i*CW +: CW];
    endfunction

    initial begin
        #12 rst_n = 1'b1;
        tick();
        check("reset dout_valid", dout_valid, 1'b0);
        check("reset options_amnt", options_amnt, '0);
        check("reset load_ready", load_ready, 1'b0);

        // Load two lines and replay them.
        load_word(16'h0000, 1); load_word(16'h0011, 0); load_word(16'h0110, 0);
        load_word(16'h1100, 0); load_word(16'h0001, 1); load_word(16'h0011, 0);
        check("load_ready in load", load_ready, 1'b1);
        finish_load();
        check("amnt0 after load", amnt_of(0), 7'd3);
        check("amnt1 after load", amnt_of(1), 7'd1);
        cyc(1, 0, '0);
        check("pop1 dout", dout, 16'h0000);
        check("pop1 is_index", dout_is_index, 1'b1);
        check("round after first idx0", round_cnt, 8'd1);
        cyc(1, 0, '0);
        check("pop2 dout", dout, 16'h0011);
        check("pop2 is_index", dout_is_index, 1'b0);
        cyc(1, 0, '0);
        check("pop3 dout", dout, 16'h0110);
        cyc(1, 0, '0);
        check("pop4 dout", dout, 16'h1100);
        cyc(1, 0, '0);
        check("pop idx1", dout, 16'h0001);
        cyc(1, 1, 16'h0110);
        check("stall with pending idx", stall, 1'b1);
        cyc(1, 0, '0);
        check("stalled pop invalid", dout_valid, 1'b0);
        check("amnt0 after commit", amnt_of(0), 7'd1);
        cyc(1, 0, '0);
        check("round2 idx0", dout, 16'h0000);
        check("round_cnt 2", round_cnt, 8'd2);
        cyc(1, 0, '0);
        check("replayed survivor", dout, 16'h0110);
        cyc(1, 0, '0);
        check("idx1 after survivor", dout, 16'h0001);
        for (int i = 0; i < 16; i++) cyc(i % 3 != 0, 0, '0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 16'h5555);
            check("read after halt", dout_valid, 1'b0);
        end

        // Asynchronous reset in the middle of RUN.
        do_reset();
        load_word(16'h0000, 1); load_word(16'h0005, 0); load_word(16'h0001, 1);
        finish_load();
        cyc(1, 0, '0);
        cyc(1, 0, '0);
        rst_n = 1'b0;
        #1;
        check("async rst dout", dout, '0);
        check("async rst dout_valid", dout_valid, 1'b0);
        check("async rst amnt", options_amnt, '0);
        check("async rst round", round_cnt, 8'd0);
        check("async rst stall", stall, 1'b0);
        #1 rst_n = 1'b1;
        tick();

        // Fill to DEPTH, then overflow on load and on put-back.
        for (int i = 0; i < D; i++) load_word(W'(i), (i % 16) == 0);
        check("full load_ready", load_ready, 1'b0);
        check("no overflow yet", overflow, 1'b0);
        load_word(16'hbeef, 0);
        check("overflow on load", overflow, 1'b1);
        finish_load();
        cyc(0, 1, 16'hcafe);
        cyc(1, 0, '0);
        check("full pop1", dout, 16'h0000);
        cyc(1, 0, '0);
        check("full pop2", dout, 16'h0001);
        for (int i = 0; i < 300; i++) cyc(1, 0, '0);

        // Read while empty.
        do_reset();
        load_word(16'h0000, 1);
        finish_load();
        cyc(1, 0, '0);
        check("single idx pop", dout_valid, 1'b1);
        cyc(1, 0, '0);
        check("empty read", dout_valid, 1'b0);
        cyc(1, 0, '0);
        check("requeued idx0", round_cnt, 8'd2);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
